// File: rtl/prbs9_dither_checker_pkg.sv
// Shared constants, FSM encoding and LFSR step for the PRBS9 dither checker.
// The same step function drives the generator model on the verification side.
package prbs9_dither_checker_pkg;

  localparam int LFSR_LEN   = 9;
  localparam int TAP_A      = 9;
  localparam int TAP_B      = 5;
  localparam int WORD_W     = 6;
  localparam int SEED_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    TRACK = 2'd2
  } chk_state_e;

  // One shift-left step with XNOR feedback entering at the LSB.
  function automatic logic [LFSR_LEN:1] lfsr_next(input logic [LFSR_LEN:1] s);
    return {s[LFSR_LEN-1:1], s[TAP_A] ~^ s[TAP_B]};
  endfunction

  function automatic logic [WORD_W-1:0] lfsr_predict(input logic [LFSR_LEN:1] s);
    logic [LFSR_LEN:1] n;
    n = lfsr_next(s);
    return n[WORD_W:1];
  endfunction

endpackage

// File: rtl/prbs9_dither_checker_syncrstgen.sv
// Reset synchronizer: asynchronous assertion, release after three CLK edges.
module prbs9_dither_checker_syncrstgen (
  input  logic CLK,
  input  logic NARST,
  output logic NRST
);

  logic [2:0] sync_r;

  // Shift ones in after NARST releases; any assertion clears the chain at once.
  always_ff @(posedge CLK or negedge NARST) begin
    if (!NARST) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], 1'b1};
    end
  end

  assign NRST = sync_r[2];

endmodule

// File: rtl/prbs9_dither_checker.sv
// Receive-side checker for the 9-bit dither LFSR: self-seeds, tracks, counts errors.
// Optional macro PRBS9_CHK_64T_EN adds the URN64T cross-check port.
module prbs9_dither_checker
  import prbs9_dither_checker_pkg::*;
#(
  parameter int ECW     = 16,
  parameter int ERR_LIM = 4
) (
  input  logic           CLK,
  input  logic           NARST,
  input  logic           VLD,
  input  logic [5:0]     URN6B,
`ifdef PRBS9_CHK_64T_EN
  input  logic [63:0]    URN64T,
`endif
  input  logic           CLR,
  output logic           LOCK,
  output logic           ERR,
  output logic [ECW-1:0] ERR_CNT,
  output logic           ERR_STKY
);

  localparam logic [3:0]     ERR_LIM_C = 4'(ERR_LIM);
  localparam logic [2:0]     SEED_LAST = 3'(SEED_WORDS - 1);
  localparam logic [ECW-1:0] CNT_MAX   = {ECW{1'b1}};

  logic nrst_s;

  chk_state_e        state_r, state_s;
  logic [LFSR_LEN:1] shadow_r, shadow_s;
  logic [2:0]        seed_cnt_r, seed_cnt_s;
  logic [3:0]        cons_cnt_r, cons_cnt_s;
  logic              lock_r, lock_s;
  logic              err_r, err_s;
  logic              stky_r, stky_s;
  logic [ECW-1:0]    cnt_r, cnt_s;

  logic [WORD_W-1:0] expect_s;
  logic [3:0]        cons_inc_s;
  logic              mismatch_s;
  logic              x64_err_s;

  prbs9_dither_checker_syncrstgen u_syncrstgen (
    .CLK   (CLK),
    .NARST (NARST),
    .NRST  (nrst_s)
  );

  // Next-state, shadow LFSR and error bookkeeping.
  always_comb begin
    state_s    = state_r;
    shadow_s   = shadow_r;
    seed_cnt_s = seed_cnt_r;
    cons_cnt_s = cons_cnt_r;
    lock_s     = lock_r;
    err_s      = 1'b0;
    cnt_s      = cnt_r;
    stky_s     = stky_r;
    mismatch_s = 1'b0;
    expect_s   = lfsr_predict(shadow_r);
    cons_inc_s = cons_cnt_r + 4'd1;
`ifdef PRBS9_CHK_64T_EN
    x64_err_s  = (URN64T != {58'd0, URN6B});
`else
    x64_err_s  = 1'b0;
`endif

    if (!VLD) begin
      if (state_r != IDLE) begin
        state_s    = IDLE;
        lock_s     = 1'b0;
        seed_cnt_s = 3'd0;
      end else begin
        state_s    = state_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          shadow_s   = {3'b000, URN6B};
          seed_cnt_s = 3'd1;
          state_s    = SEED;
        end
        SEED: begin
          mismatch_s = x64_err_s;
          // The new word's upper five bits must repeat the previous word's lower five.
          if (URN6B[5:1] != shadow_r[5:1]) begin
            shadow_s   = {3'b000, URN6B};
            seed_cnt_s = 3'd1;
          end else begin
            shadow_s   = {shadow_r[LFSR_LEN-1:1], URN6B[0]};
            seed_cnt_s = seed_cnt_r + 3'd1;
            if (seed_cnt_r == SEED_LAST) begin
              state_s    = TRACK;
              lock_s     = 1'b1;
              cons_cnt_s = 4'd0;
            end else begin
              state_s    = SEED;
            end
          end
        end
        TRACK: begin
          shadow_s   = {shadow_r[LFSR_LEN-1:1], URN6B[0]};
          mismatch_s = (URN6B != expect_s) || x64_err_s;
          if (!mismatch_s) begin
            cons_cnt_s = 4'd0;
          end else begin
            cons_cnt_s = cons_cnt_r;
          end
        end
        default: begin
          state_s    = IDLE;
          lock_s     = 1'b0;
          seed_cnt_s = 3'd0;
        end
      endcase

      if (mismatch_s) begin
        err_s      = 1'b1;
        cons_cnt_s = cons_inc_s;
        if (cons_inc_s == ERR_LIM_C) begin
          state_s    = IDLE;
          lock_s     = 1'b0;
          seed_cnt_s = 3'd0;
        end else begin
          lock_s     = lock_s;
        end
      end else begin
        err_s = 1'b0;
      end
    end

    // CLR beats a coincident error for the counter and sticky flag.
    if (CLR) begin
      cnt_s  = {ECW{1'b0}};
      stky_s = 1'b0;
    end else if (err_s) begin
      stky_s = 1'b1;
      if (cnt_r != CNT_MAX) begin
        cnt_s = cnt_r + ECW'(1);
      end else begin
        cnt_s = cnt_r;
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State and output registers on the synchronized reset.
  always_ff @(posedge CLK or negedge nrst_s) begin
    if (!nrst_s) begin
      state_r    <= IDLE;
      shadow_r   <= {LFSR_LEN{1'b0}};
      seed_cnt_r <= 3'd0;
      cons_cnt_r <= 4'd0;
      lock_r     <= 1'b0;
      err_r      <= 1'b0;
      stky_r     <= 1'b0;
      cnt_r      <= {ECW{1'b0}};
    end else begin
      state_r    <= state_s;
      shadow_r   <= shadow_s;
      seed_cnt_r <= seed_cnt_s;
      cons_cnt_r <= cons_cnt_s;
      lock_r     <= lock_s;
      err_r      <= err_s;
      stky_r     <= stky_s;
      cnt_r      <= cnt_s;
    end
  end

  assign LOCK     = lock_r;
  assign ERR      = err_r;
  assign ERR_CNT  = cnt_r;
  assign ERR_STKY = stky_r;

endmodule

// File: tb/tb_prbs9_dither_checker.sv
// Scoreboard bench for prbs9_dither_checker: generator model drives words, a
// bit-history reference model predicts outputs, a negedge monitor compares.
module tb_prbs9_dither_checker;
  import prbs9_dither_checker_pkg::*;

  localparam int ECW     = 4;
  localparam int ERR_LIM = 4;

  logic           CLK;
  logic           NARST;
  logic           VLD;
  logic [5:0]     URN6B;
  logic           CLR;
  logic           LOCK;
  logic           ERR;
  logic [ECW-1:0] ERR_CNT;
  logic           ERR_STKY;
`ifdef PRBS9_CHK_64T_EN
  logic [63:0]    URN64T;
  assign URN64T = {58'd0, URN6B};
`endif

  prbs9_dither_checker #(.ECW(ECW), .ERR_LIM(ERR_LIM)) dut (
    .CLK      (CLK),
    .NARST    (NARST),
    .VLD      (VLD),
    .URN6B    (URN6B),
`ifdef PRBS9_CHK_64T_EN
    .URN64T   (URN64T),
`endif
    .CLR      (CLR),
    .LOCK     (LOCK),
    .ERR      (ERR),
    .ERR_CNT  (ERR_CNT),
    .ERR_STKY (ERR_STKY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic           lock;
    logic           err;
    logic [ECW-1:0] cnt;
    logic           stky;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase;

  // Reference model: the shadow is simply the last nine stream bits (oldest first).
  bit                m_hist[$];
  int                m_run;
  int                m_consec;
  int                m_sync;
  int                m_cnt;
  bit                m_locked;
  bit                m_stky;
  bit                m_err;
  logic [LFSR_LEN:1] gen;

  function automatic void check(string tag, obs_t got, obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got lock=%0b err=%0b cnt=%0d stky=%0b, expected lock=%0b err=%0b cnt=%0d stky=%0b",
               tag, got.lock, got.err, got.cnt, got.stky, want.lock, want.err, want.cnt, want.stky);
    end
  endfunction

  function automatic void model_load(logic [5:0] w);
    m_hist.delete();
    for (int i = 0; i < 3; i++) m_hist.push_back(1'b0);
    for (int i = 5; i >= 0; i--) m_hist.push_back(w[i]);
  endfunction

  function automatic void model_shift(bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endfunction

  function automatic logic [4:0] model_tail5();
    return {m_hist[4], m_hist[5], m_hist[6], m_hist[7], m_hist[8]};
  endfunction

  function automatic logic [5:0] model_predict();
    return {model_tail5(), m_hist[0] ~^ m_hist[4]};
  endfunction

  function automatic void model_clear();
    m_run = 0; m_consec = 0; m_cnt = 0;
    m_locked = 1'b0; m_stky = 1'b0; m_err = 1'b0;
    model_load(6'd0);
  endfunction

  function automatic void model_edge(logic v, logic [5:0] w, logic c);
    logic [5:0] pred;
    m_err = 1'b0;
    if (!NARST) begin
      m_sync = 0;
      model_clear();
    end else if (m_sync < 3) begin
      m_sync++;
    end else begin
      if (!v) begin
        m_locked = 1'b0;
        m_run    = 0;
      end else if (!m_locked) begin
        if (m_run == 0 || w[5:1] != model_tail5()) begin
          model_load(w);
          m_run = 1;
        end else begin
          model_shift(w[0]);
          m_run++;
          if (m_run == SEED_WORDS) begin
            m_locked = 1'b1;
            m_consec = 0;
          end
        end
      end else begin
        pred = model_predict();
        model_shift(w[0]);
        if (w != pred) begin
          m_err = 1'b1;
          m_consec++;
          if (m_consec == ERR_LIM) begin
            m_locked = 1'b0;
            m_run    = 0;
          end
        end else begin
          m_consec = 0;
        end
      end
      if (c) begin
        m_cnt  = 0;
        m_stky = 1'b0;
      end else if (m_err) begin
        m_stky = 1'b1;
        if (m_cnt < (1 << ECW) - 1) m_cnt++;
      end
    end
  endfunction

  task automatic step(input logic v, input logic [5:0] w, input logic c);
    obs_t e;
    VLD   = v;
    URN6B = w;
    CLR   = c;
    model_edge(v, w, c);
    @(posedge CLK);
    #1;
    e.lock = m_locked;
    e.err  = m_err;
    e.cnt  = ECW'(m_cnt);
    e.stky = m_stky;
    exp_q.push_back(e);
    tag_q.push_back(phase);
  endtask

  task automatic send(input logic [5:0] mask, input logic c);
    step(1'b1, gen[6:1] ^ mask, c);
    gen = lfsr_next(gen);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 6'($urandom), 1'b0);
      gen = 9'd1;
    end
  endtask

  task automatic reset_mid();
    obs_t got;
    @(negedge CLK);
    #1;
    NARST = 1'b0;
    #1;
    got = {LOCK, ERR, ERR_CNT, ERR_STKY};
    check("reset_async", got, obs_t'(0));
  endtask

  // Monitor: one scoreboard entry per cycle, sampled on the falling edge.
  always @(negedge CLK) begin
    obs_t got;
    obs_t want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {LOCK, ERR, ERR_CNT, ERR_STKY};
      check(tag_q.pop_front(), got, want);
    end
  end

  initial begin
    int r;
    logic [5:0] mask;
    NARST = 1'b0; VLD = 1'b0; URN6B = 6'd0; CLR = 1'b0;
    gen = 9'd1; m_sync = 0;
    model_clear();

    phase = "reset";
    repeat (3) step(1'b0, 6'd0, 1'b0);
    NARST = 1'b1;
    phase = "sync";
    gap(3);
    phase = "seed";
    repeat (4) send(6'h00, 1'b0);
    phase = "track";
    send(6'h00, 1'b0);
    phase = "single_err";
    send(6'h02, 1'b0);
    repeat (4) send(6'h00, 1'b0);
    phase = "lose_lock";
    repeat (ERR_LIM) send(6'h02, 1'b0);
    phase = "relock";
    repeat (8) send(6'h00, 1'b0);
    phase = "vld_gap";
    gap(3);
    repeat (8) send(6'h00, 1'b0);
    phase = "saturate";
    repeat (17) begin
      send(6'h02, 1'b0);
      send(6'h00, 1'b0);
    end
    phase = "clr_with_err";
    send(6'h02, 1'b1);
    send(6'h00, 1'b0);
    send(6'h02, 1'b0);
    send(6'h00, 1'b1);

    phase = "random";
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      if (r < 6) begin
        gap(1);
      end else begin
        mask = ($urandom_range(99) < 10) ? 6'($urandom_range(63, 1)) : 6'd0;
        send(mask, ($urandom_range(99) < 3) ? 1'b1 : 1'b0);
      end
    end

    phase = "pre_reset";
    gap(1);
    repeat (6) send(6'h00, 1'b0);
    send(6'h01, 1'b0);
    reset_mid();
    phase = "in_reset";
    model_clear();
    m_sync = 0;
    repeat (2) send(6'h00, 1'b0);
    NARST = 1'b1;
    phase = "post_reset";
    gen = 9'd1;
    repeat (12) send(6'h00, 1'b0);

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
